mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Single-port memory arbiter/sequencer shared by the fetch stage (instruction read) and the memory stage (data read/write) of the 5-stage pipeline.
- Grants one requester at a time and holds the access for a fixed MEM_LAT cycles.
- Returns a one-cycle done pulse with read data, and drives the stall signals that the hazard logic uses to freeze the PC and pipeline latches.

Parameters:
- MEM_LAT, 2, memory access latency in cycles (legal range 1..7).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held high until if_done
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DW  instruction word
- if_stall  out  1  fetch must hold
- dm_req  in  1  data request; held high until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_done  out  1  one-cycle pulse; dm_rdata valid this cycle (reads)
- dm_rdata  out  DW  load data
- dm_stall  out  1  memory stage must hold
- mem_en  out  1  memory access active
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  latched address
- mem_wdata  out  DW  latched write data
- mem_rdata  in  DW  memory read data; valid in last access cycle
- err  out  1  sticky: granted access had addr[0]=1

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset:
  - state=IDLE, cnt=0, starve=0, err=0.
  - All outputs 0, including mem_* and *_rdata.
- States: IDLE, BUSY_I, BUSY_D.
- Grant decision (at each grant point):
  - Only dm_req: grant D.
  - Only if_req: grant I.
  - Both pending: grant D unless starve=1, then grant I.
- Grant point:
  - In IDLE, grant is taken in the cycle a request is seen.
  - Next cycle enters BUSY_x with cnt=MEM_LAT-1.
  - At grant, latch addr/wr/wdata into mem_addr/mem_wr/mem_wdata. Requester changes after grant are ignored.
- BUSY_x:
  - mem_en=1; mem_wr=latched wr (BUSY_D only, else 0).
  - cnt decrements each cycle.
  - Done cycle is cnt==0:
    - Assert x_done=1.
    - Drive x_rdata=mem_rdata combinationally (D write: dm_rdata=0).
- Transition out of the done cycle:
  - Re-arbitrate, ignoring the completing requester's req (it is still high this cycle).
  - If the other requester is pending, go directly to its BUSY state with no idle bubble, latching its fields.
  - Otherwise go to IDLE.
- Latency: request in cycle 0 in IDLE gives done in cycle MEM_LAT. Throughput is one access per MEM_LAT cycles when back-to-back.
- Starvation guard:
  - starve sets when a D grant is made while if_req is pending.
  - starve clears on any I grant.
  - Guarantees fetch waits at most one data access beyond the current one.
- Stalls (combinational):
  - if_stall = if_req & ~if_done.
  - dm_stall = dm_req & ~dm_done.
- err: sets on grant with addr[0]=1. The access still proceeds. err clears only on rst.
- Reset mid-operation:
  - Aborts immediately next cycle: mem_en=0, mem_wr=0, no done pulse.
  - Memory contents at the aborted write address are undefined.
- Requests dropped before done are a protocol violation. The access still completes and done still pulses.
- Width rules: mem_addr and rdata pass through unmodified, with no address arithmetic.

Test Plan:
- Reset, then idle, then a lone fetch (MEM_LAT=2):
  - Setup: if_req=1, if_addr=0x0010, mem_rdata=0xA5A5.
  - Expect mem_en high in cycles 1-2, mem_wr=0, if_done pulse in cycle 2 with if_rdata=0xA5A5.
  - Expect if_stall=1 in cycles 0-1 and 0 in cycle 2.
- Simultaneous requests in cycle 0:
  - Setup: if_req, plus dm_req with dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234.
  - Expect D served first: mem_wr=1, mem_addr=0x0200, mem_wdata=0x1234 in cycles 1-2, dm_done in cycle 2.
  - Expect I served in cycles 3-4, no bubble, if_done in cycle 4.
- Starvation:
  - Setup: dm_req re-asserted immediately after every dm_done, if_req held.
  - Expect grant order D, I, D, I. if_done occurs no later than cycle 4.
- Address change after grant:
  - Setup: change dm_addr to 0xFFFE in cycle 1.
  - Expect mem_addr to stay at the granted value through done.
- Reset mid-access:
  - Setup: assert rst in cycle 1 of a D write.
  - Expect cycle 2: mem_en=0, mem_wr=0, dm_done=0, state IDLE.
  - Expect a new if_req to then complete normally.
- Unaligned access:
  - Setup: if_addr=0x0003.
  - Expect the access completes and err=1 from the cycle after the grant.
  - Expect err to stay 1 across later accesses until rst.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory sequencer shared by instruction fetch and
// the data memory stage. One requester owns the memory for MEM_LAT cycles;
// data wins ties unless fetch has already been passed over once.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  // Countdown loaded at grant; the access finishes when it reaches zero.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [2:0]    cnt;
  logic          starve;
  logic          wrQ;
  logic [AW-1:0] addrQ;
  logic [DW-1:0] wdataQ;

  logic ifDoneInt;
  logic dmDoneInt;
  logic busyDone;
  logic ifPend;
  logic dmPend;
  logic grantPoint;
  logic grantD;
  logic grantI;

  // Arbitration: the completing requester's still-high request is masked so
  // the other side can take over in the very next cycle without a bubble.
  always_comb begin
    ifDoneInt  = (state == BUSY_I) && (cnt == 3'd0);
    dmDoneInt  = (state == BUSY_D) && (cnt == 3'd0);
    busyDone   = ifDoneInt | dmDoneInt;
    ifPend     = if_req & ~ifDoneInt;
    dmPend     = dm_req & ~dmDoneInt;
    grantPoint = (state == IDLE) | busyDone;
    grantD     = grantPoint & dmPend & (~ifPend | ~starve);
    grantI     = grantPoint & ifPend & ~grantD;
  end

  // Sequencer state, access latches, starvation flag and sticky alignment error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 3'd0;
      starve <= 1'b0;
      err    <= 1'b0;
      wrQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
    end else if (grantD) begin
      state  <= BUSY_D;
      cnt    <= LAT_M1;
      wrQ    <= dm_wr;
      addrQ  <= dm_addr;
      wdataQ <= dm_wdata;
      if (ifPend)     starve <= 1'b1;
      if (dm_addr[0]) err    <= 1'b1;
    end else if (grantI) begin
      state  <= BUSY_I;
      cnt    <= LAT_M1;
      wrQ    <= 1'b0;
      addrQ  <= if_addr;
      wdataQ <= '0;
      starve <= 1'b0;
      if (if_addr[0]) err <= 1'b1;
    end else if (busyDone) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else if (state != IDLE) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Memory strobes, done pulses with pass-through read data, and stalls.
  always_comb begin
    mem_en    = (state != IDLE);
    mem_wr    = (state == BUSY_D) & wrQ;
    mem_addr  = addrQ;
    mem_wdata = wdataQ;
    if_done   = ifDoneInt;
    dm_done   = dmDoneInt;
    if_rdata  = ifDoneInt ? mem_rdata : '0;
    dm_rdata  = (dmDoneInt & ~wrQ) ? mem_rdata : '0;
    if_stall  = if_req & ~ifDoneInt;
    dm_stall  = dm_req & ~dmDoneInt;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (MEM_LAT=2): cycle-by-cycle vector table plus a
// reactive sequence with both requesters continuously asking.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_done;
  logic [15:0] dm_rdata;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
  );

  // fl = {if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr, err}
  typedef struct {
    logic        chk;
    logic        rst;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        dmReq;
    logic        dmWr;
    logic [15:0] dmAddr;
    logic [15:0] dmWdata;
    logic [15:0] memRdata;
    logic [6:0]  fl;
    logic [15:0] ifRdata;
    logic [15:0] dmRdata;
    logic        chkMem;
    logic [15:0] eAddr;
    logic [15:0] eWdata;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic c, input logic r, input logic ir, input logic [15:0] ia,
                   input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                   input logic [15:0] mrd, input logic [6:0] fl, input logic [15:0] ird,
                   input logic [15:0] drd, input logic cm, input logic [15:0] ea,
                   input logic [15:0] ew);
    vec_t x;
    x.chk = c; x.rst = r; x.ifReq = ir; x.ifAddr = ia; x.dmReq = dr; x.dmWr = dw;
    x.dmAddr = da; x.dmWdata = dwd; x.memRdata = mrd; x.fl = fl; x.ifRdata = ird;
    x.dmRdata = drd; x.chkMem = cm; x.eAddr = ea; x.eWdata = ew;
    vecs.push_back(x);
  endtask

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic [15:0] ia, input logic dr,
                       input logic dw, input logic [15:0] da, input logic [15:0] dwd,
                       input logic [15:0] mrd);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_wr = dw;
    dm_addr = da; dm_wdata = dwd; mem_rdata = mrd;
  endtask

  initial begin
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);

    // reset and reset state
    v(0,1,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,1,16'h0,16'h0);
    // lone fetch
    v(1,0,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5,7'b0100000,16'h0,16'h0,1,16'h0,16'h0);
    v(1,0,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5,7'b0100100,16'h0,16'h0,1,16'h0010,16'h0);
    v(1,0,1,16'h0010,0,0,16'h0000,16'h0000,16'hA5A5,7'b1000100,16'hA5A5,16'h0,1,16'h0010,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);
    // simultaneous: data write first, then fetch with no bubble
    v(1,0,1,16'h0020,1,1,16'h0200,16'h1234,16'h5A5A,7'b0101000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,1,16'h0020,1,1,16'h0200,16'h1234,16'h5A5A,7'b0101110,16'h0,16'h0,1,16'h0200,16'h1234);
    v(1,0,1,16'h0020,1,1,16'h0200,16'h1234,16'h5A5A,7'b0110110,16'h0,16'h0,1,16'h0200,16'h1234);
    v(1,0,1,16'h0020,0,0,16'h0000,16'h0000,16'h5A5A,7'b0100100,16'h0,16'h0,1,16'h0020,16'h0);
    v(1,0,1,16'h0020,0,0,16'h0000,16'h0000,16'h5A5A,7'b1000100,16'h5A5A,16'h0,1,16'h0020,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);
    // data read; requester fields change after grant
    v(1,0,0,16'h0000,1,0,16'h0100,16'h4444,16'hBEEF,7'b0001000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,0,16'h0000,1,1,16'hFFFE,16'h9999,16'hBEEF,7'b0001100,16'h0,16'h0,1,16'h0100,16'h4444);
    v(1,0,0,16'h0000,1,1,16'hFFFE,16'h9999,16'hBEEF,7'b0010100,16'h0,16'hBEEF,1,16'h0100,16'h4444);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);
    // unaligned fetch sets sticky err
    v(1,0,1,16'h0003,0,0,16'h0000,16'h0000,16'h1111,7'b0100000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,1,16'h0003,0,0,16'h0000,16'h0000,16'h1111,7'b0100101,16'h0,16'h0,1,16'h0003,16'h0);
    v(1,0,1,16'h0003,0,0,16'h0000,16'h0000,16'h1111,7'b1000101,16'h1111,16'h0,1,16'h0003,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000001,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,0,16'h0000,1,0,16'h0004,16'h0000,16'h2222,7'b0001001,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,0,16'h0000,1,0,16'h0004,16'h0000,16'h2222,7'b0001101,16'h0,16'h0,1,16'h0004,16'h0);
    v(1,0,0,16'h0000,1,0,16'h0004,16'h0000,16'h2222,7'b0010101,16'h0,16'h2222,1,16'h0004,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000001,16'h0,16'h0,0,16'h0,16'h0);
    v(0,1,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,1,16'h0,16'h0);
    // reset in the middle of a data write, then a normal fetch
    v(1,0,0,16'h0000,1,1,16'h0300,16'h7777,16'h0000,7'b0001000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,1,0,16'h0000,1,1,16'h0300,16'h7777,16'h0000,7'b0001110,16'h0,16'h0,1,16'h0300,16'h7777);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,1,16'h0,16'h0);
    v(1,0,1,16'h0040,0,0,16'h0000,16'h0000,16'h3333,7'b0100000,16'h0,16'h0,0,16'h0,16'h0);
    v(1,0,1,16'h0040,0,0,16'h0000,16'h0000,16'h3333,7'b0100100,16'h0,16'h0,1,16'h0040,16'h0);
    v(1,0,1,16'h0040,0,0,16'h0000,16'h0000,16'h3333,7'b1000100,16'h3333,16'h0,1,16'h0040,16'h0);
    v(1,0,0,16'h0000,0,0,16'h0000,16'h0000,16'h0000,7'b0000000,16'h0,16'h0,0,16'h0,16'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].ifReq, vecs[i].ifAddr, vecs[i].dmReq, vecs[i].dmWr,
            vecs[i].dmAddr, vecs[i].dmWdata, vecs[i].memRdata);
      #2;
      if (vecs[i].chk) begin
        cmp("if_done",  i, 32'(if_done),  32'(vecs[i].fl[6]));
        cmp("if_stall", i, 32'(if_stall), 32'(vecs[i].fl[5]));
        cmp("dm_done",  i, 32'(dm_done),  32'(vecs[i].fl[4]));
        cmp("dm_stall", i, 32'(dm_stall), 32'(vecs[i].fl[3]));
        cmp("mem_en",   i, 32'(mem_en),   32'(vecs[i].fl[2]));
        cmp("mem_wr",   i, 32'(mem_wr),   32'(vecs[i].fl[1]));
        cmp("err",      i, 32'(err),      32'(vecs[i].fl[0]));
        cmp("if_rdata", i, 32'(if_rdata), 32'(vecs[i].ifRdata));
        cmp("dm_rdata", i, 32'(dm_rdata), 32'(vecs[i].dmRdata));
        if (vecs[i].chkMem) begin
          cmp("mem_addr",  i, 32'(mem_addr),  32'(vecs[i].eAddr));
          cmp("mem_wdata", i, 32'(mem_wdata), 32'(vecs[i].eWdata));
        end
      end
    end

    // Both requesters ask continuously: completions must alternate D,I,D,I
    // every MEM_LAT cycles with the memory busy throughout.
    begin
      byte expKind[4];
      int  expCyc[4];
      byte gotKind[4];
      int  gotCyc[4];
      int  nDone;
      expKind[0] = "D"; expKind[1] = "I"; expKind[2] = "D"; expKind[3] = "I";
      expCyc[0] = 2; expCyc[1] = 4; expCyc[2] = 6; expCyc[3] = 8;
      nDone = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'hC0DE);
        #2;
        if (c >= 1 && c <= 8) cmp("starve mem_en", c, 32'(mem_en), 32'd1);
        if (if_done && dm_done) cmp("starve dual done", c, 32'd1, 32'd0);
        if (nDone < 4 && (if_done || dm_done)) begin
          gotKind[nDone] = dm_done ? 8'("D") : 8'("I");
          gotCyc[nDone]  = c;
          nDone++;
        end
      end
      cmp("starve completions", 0, 32'(nDone), 32'd4);
      for (int k = 0; k < 4; k++) begin
        if (k < nDone) begin
          cmp("starve order", k, 32'(gotKind[k]), 32'(expKind[k]));
          cmp("starve cycle", k, 32'(gotCyc[k]),  32'(expCyc[k]));
        end
      end
    end

    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    cmp("final reset mem_en", 0, 32'(mem_en), 32'd0);
    cmp("final reset err",    0, 32'(err),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
